// File: rtl/alu_pkg.sv
// Opcode encodings (MIPS funct field) and legality check shared by alu_pipe and alu_core.
// Defining ALU_EXT_OPS_EN adds SLL and SLT to the legal opcode set.
package alu_pkg;

    localparam int OP_W = 6;
    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_ADD = 6'b100000;
    localparam op_t OP_SUB = 6'b100010;
    localparam op_t OP_AND = 6'b100100;
    localparam op_t OP_OR  = 6'b100101;
    localparam op_t OP_XOR = 6'b100110;
    localparam op_t OP_NOR = 6'b100111;
    localparam op_t OP_SRA = 6'b000011;
    localparam op_t OP_SRL = 6'b000010;
    localparam op_t OP_SLL = 6'b000000;
    localparam op_t OP_SLT = 6'b101010;

    function automatic logic is_legal_op(input op_t op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: legal = 1'b1;
`ifdef ALU_EXT_OPS_EN
            OP_SLL, OP_SLT:                 legal = 1'b1;
`endif
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result plus zero/carry/overflow/illegal flags from op/a/b.
// SLL and SLT are decoded only when ALU_EXT_OPS_EN is defined; otherwise they are illegal.
module alu_core #(
    parameter int N_BITS = 8,
    parameter int N_OP   = 6
) (
    input  logic [N_OP-1:0]   op_i,
    input  logic [N_BITS-1:0] a_i,
    input  logic [N_BITS-1:0] b_i,
    output logic [N_BITS-1:0] res_o,
    output logic              zero_o,
    output logic              carry_o,
    output logic              overflow_o,
    output logic              illegal_o
);
    import alu_pkg::*;

    localparam int MSB = N_BITS - 1;
    localparam logic [N_BITS-1:0] SH_LIMIT = N_BITS'(N_BITS);

    op_t               op_n;
    logic              legal;
    logic              too_far;
    logic [N_BITS-1:0] b_neg;
    logic [N_BITS:0]   wide;
    logic [N_BITS-1:0] res;
    logic              carry;
    logic              ovf;

    // Opcodes wider than the funct field are legal only if the extra bits are zero.
    assign op_n    = op_t'(op_i);
    assign legal   = is_legal_op(op_n) && ((op_i >> OP_W) == '0);
    assign too_far = (b_i >= SH_LIMIT);
    assign b_neg   = ~b_i + N_BITS'(1);

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        wide  = '0;
        if (legal) begin
            case (op_n)
                OP_ADD: begin
                    wide  = {1'b0, a_i} + {1'b0, b_i};
                    res   = wide[N_BITS-1:0];
                    carry = wide[N_BITS];
                    ovf   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
                end
                OP_SUB: begin
                    wide  = {1'b0, a_i} - {1'b0, b_i};
                    res   = wide[N_BITS-1:0];
                    carry = wide[N_BITS];
                    ovf   = (a_i[MSB] == b_neg[MSB]) && (res[MSB] != a_i[MSB]);
                end
                OP_AND: res = a_i & b_i;
                OP_OR:  res = a_i | b_i;
                OP_XOR: res = a_i ^ b_i;
                OP_NOR: res = ~(a_i | b_i);
                OP_SRA: res = too_far ? {N_BITS{a_i[MSB]}} : N_BITS'($signed(a_i) >>> b_i);
                OP_SRL: res = too_far ? '0 : (a_i >> b_i);
`ifdef ALU_EXT_OPS_EN
                OP_SLL: res = too_far ? '0 : (a_i << b_i);
                OP_SLT: res = N_BITS'($signed(a_i) < $signed(b_i));
`endif
                default: res = '0;
            endcase
        end
    end

    assign res_o      = res;
    assign zero_o     = (res == '0);
    assign carry_o    = carry;
    assign overflow_o = ovf;
    assign illegal_o  = !legal;

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with status flags and a saturating illegal-op counter.
// ALU_EXT_OPS_EN (see alu_pkg/alu_core) enables the SLL/SLT opcodes.
module alu_pipe #(
    parameter int N_BITS   = 8,
    parameter int N_OP     = 6,
    parameter int CNT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N_OP-1:0]     Op,
    input  logic [N_BITS-1:0]   A,
    input  logic [N_BITS-1:0]   B,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   salida,
    output logic                zero,
    output logic                carry,
    output logic                overflow,
    output logic                illegal,
    output logic [CNT_BITS-1:0] err_count
);
    import alu_pkg::*;

    logic                s1_valid_q, s2_valid_q;
    logic [N_OP-1:0]     s1_op_q;
    logic [N_BITS-1:0]   s1_a_q, s1_b_q;
    logic [N_BITS-1:0]   salida_q;
    logic                zero_q, carry_q, overflow_q, illegal_q;
    logic [CNT_BITS-1:0] err_count_q, err_count_d;

    logic                s1_adv, s2_adv, accept, acc_illegal;
    logic [N_BITS-1:0]   core_res;
    logic                core_zero, core_carry, core_ovf, core_ill;

    assign s2_adv      = !s2_valid_q || out_ready;
    assign s1_adv      = !s1_valid_q || s2_adv;
    assign in_ready    = s1_adv;
    assign accept      = in_valid && s1_adv;
    assign acc_illegal = !is_legal_op(op_t'(Op)) || ((Op >> OP_W) != '0);

    always_comb begin
        err_count_d = err_count_q;
        if (accept && acc_illegal && (err_count_q != '1))
            err_count_d = err_count_q + CNT_BITS'(1);
    end

    alu_core #(.N_BITS(N_BITS), .N_OP(N_OP)) u_core (
        .op_i       (s1_op_q),
        .a_i        (s1_a_q),
        .b_i        (s1_b_q),
        .res_o      (core_res),
        .zero_o     (core_zero),
        .carry_o    (core_carry),
        .overflow_o (core_ovf),
        .illegal_o  (core_ill)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            salida_q    <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= in_valid;
            if (s2_adv) s2_valid_q <= s1_valid_q;
            if (s2_adv && s1_valid_q) begin
                salida_q   <= core_res;
                zero_q     <= core_zero;
                carry_q    <= core_carry;
                overflow_q <= core_ovf;
                illegal_q  <= core_ill;
            end
            err_count_q <= err_count_d;
        end
    end

    // NOTE: stage-1 operands need no reset; s1_valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_q <= Op;
            s1_a_q  <= A;
            s1_b_q  <= B;
        end
    end

    assign out_valid = s2_valid_q;
    assign salida    = salida_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: opcodes, flags, latency, backpressure,
// counter saturation (CNT_BITS=2 instance) and mid-operation reset.
module tb_alu_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, in_valid, in_ready, out_valid, out_ready;
    logic [5:0] Op;
    logic [7:0] A, B, salida, err_count;
    logic       zero, carry, overflow, illegal;

    logic       in_valid2, in_ready2, out_valid2, out_ready2;
    logic [5:0] Op2;
    logic [7:0] A2, B2, salida2;
    logic       zero2, carry2, overflow2, illegal2;
    logic [1:0] err_count2;

    alu_pipe #(.N_BITS(8), .N_OP(6), .CNT_BITS(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Op(Op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .salida(salida), .zero(zero), .carry(carry), .overflow(overflow),
        .illegal(illegal), .err_count(err_count)
    );

    alu_pipe #(.N_BITS(8), .N_OP(6), .CNT_BITS(2)) dut_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .Op(Op2), .A(A2), .B(B2), .out_valid(out_valid2), .out_ready(out_ready2),
        .salida(salida2), .zero(zero2), .carry(carry2), .overflow(overflow2),
        .illegal(illegal2), .err_count(err_count2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Flags are compared packed as {zero, carry, overflow, illegal}.
    task automatic exec_op(input string tag, input op_t op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_res, input logic [3:0] exp_flags);
        Op = op; A = a; B = b; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        step();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, 32'(salida), 32'(exp_res));
        check({tag, "_flags"}, 32'({zero, carry, overflow, illegal}), 32'(exp_flags));
    endtask

    logic [7:0] got_q[$];
    int         acc;
    int         sent;

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; Op = '0; A = '0; B = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; Op2 = '0; A2 = '0; B2 = '0;
        repeat (2) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_salida", 32'(salida), 32'd0);
        check("rst_flags", 32'({zero, carry, overflow, illegal}), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_count2", 32'(err_count2), 32'd0);
        reset = 1'b0;

        exec_op("add_ovf",    OP_ADD, 8'd127, 8'd1,  8'h80, 4'b0010);
        exec_op("add_carry",  OP_ADD, 8'hFF,  8'h01, 8'h00, 4'b1100);
        exec_op("sub_borrow", OP_SUB, 8'd0,   8'd1,  8'hFF, 4'b0100);
        exec_op("sub_zero",   OP_SUB, 8'd5,   8'd5,  8'h00, 4'b1000);
        exec_op("and",        OP_AND, 8'hCA,  8'h0F, 8'h0A, 4'b0000);
        exec_op("or",         OP_OR,  8'hCA,  8'h0F, 8'hCF, 4'b0000);
        exec_op("xor",        OP_XOR, 8'hCA,  8'h0F, 8'hC5, 4'b0000);
        exec_op("nor",        OP_NOR, 8'hCA,  8'h0F, 8'h30, 4'b0000);
        exec_op("sra3",       OP_SRA, 8'h80,  8'd3,  8'hF0, 4'b0000);
        exec_op("srl3",       OP_SRL, 8'h80,  8'd3,  8'h10, 4'b0000);
        exec_op("sra9",       OP_SRA, 8'h80,  8'd9,  8'hFF, 4'b0000);
        exec_op("srl9",       OP_SRL, 8'h80,  8'd9,  8'h00, 4'b1000);
        exec_op("ill_1",      6'h3F,  8'd3,   8'd4,  8'h00, 4'b1001);
        check("ill_cnt1", 32'(err_count), 32'd1);
        exec_op("ill_2",      6'h3F,  8'd7,   8'd9,  8'h00, 4'b1001);
        check("ill_cnt2", 32'(err_count), 32'd2);

        // Backpressure: drain, then push ADDs with the sink stalled.
        step();
        check("bp_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            Op = OP_ADD; A = 8'(acc + 1); B = 8'(acc + 1); in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            step();
        end
        check("bp_accepts", 32'(acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_res", 32'(salida), 32'd2);
        step();
        check("bp_stable_valid", 32'(out_valid), 32'd1);
        check("bp_stable_res", 32'(salida), 32'd2);
        check("bp_stable_flags", 32'({zero, carry, overflow, illegal}), 32'd0);

        out_ready = 1'b1;
        sent = acc;
        for (int cyc = 0; cyc < 20 && got_q.size() < 4; cyc++) begin
            if (sent < 4) begin
                Op = OP_ADD; A = 8'(sent + 1); B = 8'(sent + 1); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid) got_q.push_back(salida);
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        check("bp_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_out%0d", i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD,
                  32'(2 * (i + 1)));

        // Saturation on the 2-bit counter instance.
        for (int i = 0; i < 5; i++) begin
            Op2 = 6'h3F; A2 = 8'(i); B2 = 8'd1; in_valid2 = 1'b1;
            step();
            if (i == 1) check("cnt2_two", 32'(err_count2), 32'd2);
        end
        in_valid2 = 1'b0;
        check("cnt2_sat", 32'(err_count2), 32'd3);

        // Reset with the pipe full.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            Op = OP_ADD; A = 8'(i); B = 8'd1; in_valid = 1'b1;
            step();
        end
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step();
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        check("post_rst_empty", 32'(out_valid), 32'd0);

`ifdef ALU_EXT_OPS_EN
        exec_op("op000000", 6'b000000, 8'd1, 8'd1, 8'h02, 4'b0000);
        check("op000000_cnt", 32'(err_count), 32'd0);
`else
        exec_op("op000000", 6'b000000, 8'd1, 8'd1, 8'h00, 4'b1001);
        check("op000000_cnt", 32'(err_count), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
